// File: rtl/fda_uart_pkg.sv
// Shared UART definitions for the host link (transmit and receive paths).
// State encoding, frame constants and default baud divider.
package fda_uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS   = 8;
  localparam int UART_STOP_BITS   = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } uart_state_e;

  function automatic logic even_parity(
    input logic [UART_DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/cmd_response_tx_if.sv
// Response-byte write port and UART line/status bundle.
// master = control FSM side, slave = cmd_response_tx.
interface cmd_response_tx_if;

  logic [7:0] TxByte;
  logic       NewTx;
  logic       full;
  logic       busy;
  logic       tx;
  logic       txDone;
  logic       overflow;

  modport master (
    output TxByte, NewTx,
    input  full, busy, tx, txDone, overflow
  );

  modport slave (
    input  TxByte, NewTx,
    output full, busy, tx, txDone, overflow
  );

endinterface

// File: rtl/resp_fifo.sv
// Circular synchronous FIFO with registered full flag.
// Pointers wrap naturally since DEPTH is a power of two.
module resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             full_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = full_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)
      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_push)
        wr_q <= wr_q + AW'(1);
      if (do_pop)
        rd_q <= rd_q + AW'(1);
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/cmd_response_tx.sv
// Response byte FIFO + UART 8N1 serialiser, LSB first, registered tx.
// Define CMD_RESPONSE_TX_PARITY_EN for an even-parity bit (8E1).
module cmd_response_tx
  import fda_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  cmd_response_tx_if.slave   bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDX_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_e st_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    sh_q;
  logic          tx_q;
  logic          done_q;
  logic          busy_q;
  logic          ovf_q;
`ifdef CMD_RESPONSE_TX_PARITY_EN
  logic          par_q;
`endif

  logic       f_full;
  logic       f_empty;
  logic [7:0] f_dout;
  logic       bit_end;
  logic       pop;

  assign bit_end = (cnt_q == CNT_LAST);
  assign pop = !f_empty &&
               ((st_q == S_IDLE) ||
                (st_q == S_STOP && bit_end));

  resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus.NewTx),
    .pop_i   (pop),
    .din_i   (bus.TxByte),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign bus.full     = f_full;
  assign bus.busy     = busy_q;
  assign bus.tx       = tx_q;
  assign bus.txDone   = done_q;
  assign bus.overflow = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      idx_q  <= '0;
      sh_q   <= '0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef CMD_RESPONSE_TX_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= (st_q == S_IDLE || bit_end) ? '0 : cnt_q + CW'(1);
      done_q <= (st_q == S_STOP) && bit_end;
      busy_q <= !f_empty || (st_q != S_IDLE);
      if (bus.NewTx && f_full)
        ovf_q <= 1'b1;

      // tx trails the state by one cycle so the pin is purely registered
      unique case (st_q)
        S_START: tx_q <= 1'b0;
        S_DATA:  tx_q <= sh_q[0];
`ifdef CMD_RESPONSE_TX_PARITY_EN
        S_PARITY: tx_q <= par_q;
`endif
        default: tx_q <= 1'b1;
      endcase

      unique case (st_q)
        S_IDLE: begin
          if (!f_empty) begin
            sh_q <= f_dout;
`ifdef CMD_RESPONSE_TX_PARITY_EN
            par_q <= even_parity(f_dout);
`endif
            st_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            idx_q <= '0;
            st_q  <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            sh_q  <= sh_q >> 1;
            idx_q <= idx_q + 3'd1;
            if (idx_q == IDX_LAST) begin
`ifdef CMD_RESPONSE_TX_PARITY_EN
              st_q <= S_PARITY;
`else
              st_q <= S_STOP;
`endif
            end
          end
        end
`ifdef CMD_RESPONSE_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end)
            st_q <= S_STOP;
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (!f_empty) begin
              sh_q <= f_dout;
`ifdef CMD_RESPONSE_TX_PARITY_EN
              par_q <= even_parity(f_dout);
`endif
              st_q <= S_START;
            end else begin
              st_q <= S_IDLE;
            end
          end
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_response_tx.sv
// Bench for cmd_response_tx: frame-level reference model, serial decoder,
// directed edge checks and random traffic.
module tb_cmd_response_tx;

  localparam int C     = 4;
  localparam int DEPTH = 4;
`ifdef CMD_RESPONSE_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * C;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cmd_response_tx_if bus();

  cmd_response_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit live  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  byte unsigned m_fifo[$];
  byte unsigned acc_q[$];
  bit m_wtx[$];
  bit m_wdn[$];
  bit e_tx = 1, e_done = 0, e_busy = 0, e_full = 0, e_ovf = 0;
  int cnt_b;
  bit m_pop, m_acc;
  byte unsigned m_b;

  function automatic void build_wave(input byte unsigned b);
    bit bits[$];
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(b[k]);
`ifdef CMD_RESPONSE_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[i])
      for (int j = 0; j < C; j++) begin
        m_wtx.push_back(bits[i]);
        m_wdn.push_back((i == bits.size() - 1) && (j == C - 1));
      end
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_fifo.delete(); acc_q.delete();
      m_wtx.delete(); m_wdn.delete();
      e_tx = 1; e_done = 0; e_busy = 0; e_full = 0; e_ovf = 0;
    end else begin
      cnt_b  = m_fifo.size();
      e_busy = (cnt_b > 0) || (m_wtx.size() > 0);
      if (m_wtx.size() > 0) begin
        e_tx   = m_wtx.pop_front();
        e_done = m_wdn.pop_front();
      end else begin
        e_tx = 1; e_done = 0;
      end
      m_pop = (m_wtx.size() == 0) && (cnt_b > 0);
      m_acc = bus.NewTx && !e_full;
      if (bus.NewTx && e_full) e_ovf = 1;
      if (m_pop) begin
        m_b = m_fifo.pop_front();
        acc_q.push_back(m_b);
        build_wave(m_b);
      end
      if (m_acc) m_fifo.push_back(bus.TxByte);
      e_full = (m_fifo.size() == DEPTH);
    end
  end

  // ---------------- per-cycle compare ----------------
  int dn_edges[$];
  always @(negedge clk) begin
    if (rst_n && live) begin
      chk("tx", bus.tx, e_tx);
      chk("txDone", bus.txDone, e_done);
      chk("busy", bus.busy, e_busy);
      chk("full", bus.full, e_full);
      chk("overflow", bus.overflow, e_ovf);
      if (bus.txDone) dn_edges.push_back(cyc);
    end
  end

  // ---------------- serial decoder ----------------
  bit rx_act = 0;
  int rx_t, rx_cnt = 0;
  byte unsigned rx_b, rx_last;
  always @(negedge clk) begin
    if (!rst_n) rx_act = 0;
    else if (!rx_act) begin
      if (bus.tx == 1'b0) begin
        rx_act = 1; rx_t = 0; rx_b = 0;
      end
    end else begin
      rx_t++;
      if (rx_t == C / 2) chk("rx_start", bus.tx, 0);
      for (int k = 0; k < 8; k++)
        if (rx_t == (k + 1) * C + C / 2) rx_b[k] = bus.tx;
`ifdef CMD_RESPONSE_TX_PARITY_EN
      if (rx_t == 9 * C + C / 2) chk("rx_parity", bus.tx, ^rx_b);
`endif
      if (rx_t == (NBITS - 1) * C + C / 2) begin
        chk("rx_stop", bus.tx, 1);
        rx_cnt++;
        rx_last = rx_b;
        if (acc_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rx_frame: got byte %0d expected no frame", rx_b);
        end else
          chk("rx_byte", rx_b, acc_q.pop_front());
        rx_act = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_byte(input byte unsigned b);
    bus.TxByte = b;
    bus.NewTx  = 1'b1;
    @(posedge clk); #1;
    bus.NewTx  = 1'b0;
  endtask

  task automatic wait_to(input int e);
    if (e > cyc) repeat (e - cyc) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((bus.busy || m_fifo.size() != 0 || m_wtx.size() != 0)
           && n < 4000) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (n >= 4000) begin
      fails++;
      $display("FAIL %s: busy still %0d after %0d cycles, need 0",
               nm, bus.busy, n);
    end
    repeat (3) @(posedge clk); #1;
  endtask

  bit lit[NBITS];
  int w, w0, r0;

  initial begin
`ifdef CMD_RESPONSE_TX_PARITY_EN
    lit = '{0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 1};
`else
    lit = '{0, 1, 0, 1, 0, 0, 0, 1, 0, 1};
`endif
    rst_n = 1'b0;
    bus.NewTx = 1'b0;
    bus.TxByte = 8'h00;
    repeat (3) @(posedge clk); #1;
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_txDone", bus.txDone, 0);
    chk("rst_overflow", bus.overflow, 0);
    rst_n = 1'b1;
    live  = 1;
    repeat (5) @(posedge clk); #1;

    // single byte 'E'
    push_byte(8'h45);
    w = cyc;
    wait_to(w + 1);
    chk("E_tx_n1", bus.tx, 1);
    chk("E_busy_n1", bus.busy, 1);
    wait_to(w + 2);
    chk("E_tx_fall_n2", bus.tx, 0);
    for (int k = 0; k < NBITS; k++) begin
      wait_to(w + 2 + k * C + C / 2);
      chk($sformatf("E_bit%0d", k), bus.tx, lit[k]);
    end
    wait_to(w + 1 + FRAME);
    chk("E_txDone", bus.txDone, 1);
    chk("E_busy_last", bus.busy, 1);
    wait_to(w + 2 + FRAME);
    chk("E_busy_low", bus.busy, 0);
    chk("E_txDone_off", bus.txDone, 0);
    drain("single");

    // back-to-back 'E','e'
    dn_edges.delete();
    push_byte(8'h45);
    w = cyc;
    push_byte(8'h65);
    drain("b2b");
    chk("b2b_done_count", dn_edges.size(), 2);
    if (dn_edges.size() == 2) begin
      chk("b2b_first_done", dn_edges[0], w + 1 + FRAME);
      chk("b2b_spacing", dn_edges[1] - dn_edges[0], FRAME);
    end

    // overflow: six writes into idle block
    r0 = rx_cnt;
    for (int i = 0; i < 6; i++) push_byte(8'(8'h10 + i));
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_full", bus.full, 1);
    drain("overflow");
    chk("ovf_frames", rx_cnt - r0, 5);
    chk("ovf_last", rx_last, 8'h14);

    // reset during data bit 3
    push_byte(8'h45);
    w = cyc;
    wait_to(w + 2 + 4 * C + 1);
    chk("pre_rst_tx", bus.tx, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", bus.tx, 1);
    chk("mid_rst_full", bus.full, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ovf", bus.overflow, 0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    r0 = rx_cnt;
    push_byte(8'h5A);
    drain("post_rst");
    chk("post_rst_frames", rx_cnt - r0, 1);
    chk("post_rst_byte", rx_last, 8'h5A);

    // write while full in the same cycle a pop frees a slot
    chk("sim_ovf_pre", bus.overflow, 0);
    push_byte(8'hA1);
    w0 = cyc;
    for (int i = 0; i < 4; i++) push_byte(8'(8'hA2 + i));
    chk("sim_full", bus.full, 1);
    wait_to(w0 + FRAME);
    chk("sim_full_before", bus.full, 1);
    push_byte(8'h33);
    chk("sim_pop_edge", bus.txDone, 1);
    chk("sim_ovf", bus.overflow, 1);
    chk("sim_full_after", bus.full, 0);
    drain("simul");

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        int n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) push_byte(8'($urandom));
      end else begin
        @(posedge clk); #1;
      end
    end
    drain("random");
    chk("all_frames_rx", acc_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
